spi_txn_arbiter: RTL and testbench
==================================

// Module: spi_txn_arbiter
//
// PURPOSE
//   Shares one spi_updated master (16-bit frame, 4 slave selects) among NREQ requesters.
//   Round-robin arbitration; per-requester 16-bit tx word and 2-bit SPI mode.
//   Drives master din/spi_mode/slave_sel plus a start pulse; waits for master done.
//   Returns the received word tagged with requester id; a watchdog aborts hung frames.
//   Requester i always addresses slave i (slave_sel = i).
//
// PARAMETERS
//   NREQ     4     number of requesters, legal 2..4 (slave_sel is 2 bits)
//   TIMEOUT  1024  max clk cycles in WAIT before abort, >= 2
//
// PORTS
//   clk          in   1        system clock, all logic on rising edge
//   rst          in   1        synchronous, active-high reset
//   req          in   NREQ     request per requester; hold high until gnt[i] seen
//   req_data     in   16*NREQ  tx word; requester i at [16*i+15:16*i]
//   req_mode     in   2*NREQ   SPI mode {CPOL,CPHA}; requester i at [2*i+1:2*i]
//   gnt          out  NREQ     one-hot, 1-cycle pulse: req_data/req_mode latched this cycle
//   rsp_valid    out  1        1-cycle pulse: response available
//   rsp_id       out  2        requester index of response
//   rsp_data     out  16       received word (0 on timeout)
//   rsp_err      out  1        1 = watchdog timeout, qualified by rsp_valid
//   busy         out  1        high in every state except IDLE
//   m_start      out  1        1-cycle start pulse to master
//   m_din        out  16       tx word to master, stable from m_start until exit of WAIT
//   m_mode       out  2        spi_mode to master, stable like m_din
//   m_slave_sel  out  2        slave_sel to master, stable like m_din
//   m_done       in   1        master frame-complete pulse
//   m_dout       in   16       master rx word, valid in m_done cycle
//
// BEHAVIOUR
//   Reset: all outputs 0; state IDLE; rr pointer = NREQ-1 (requester 0 highest priority first).
//   FSM: IDLE -> GRANT -> WAIT -> RESP -> IDLE.
//   IDLE: if |req, pick winner w = first set bit searching from (ptr+1) mod NREQ upward.
//     Transition to GRANT.
//   GRANT (1 cycle): gnt[w]=1, m_start=1.
//     Latch m_din = req_data[w], m_mode = req_mode[w], m_slave_sel = w, rsp_id = w.
//     ptr <= w. Transition to WAIT; watchdog count cleared.
//   WAIT: count++ each cycle.
//     On m_done: capture rsp_data = m_dout, rsp_err = 0, go to RESP.
//     If count reaches TIMEOUT-1 without m_done: rsp_data = 0, rsp_err = 1, go to RESP.
//     m_done and timeout in the same cycle: m_done wins.
//   RESP (1 cycle): rsp_valid = 1, then IDLE. rsp_id/rsp_data/rsp_err hold until the next RESP.
//   Latency: req sampled in IDLE at cycle t -> gnt/m_start at t+1;
//     m_done at cycle d -> rsp_valid at d+1.
//   Back-to-back: min 1 IDLE cycle between RESP and the next GRANT.
//     Frame period = frame length + 3 cycles.
//   req is sampled only in IDLE; deassertion during GRANT/WAIT/RESP has no effect.
//   m_done outside WAIT is ignored.
//   gnt and m_start are never high outside GRANT; at most one gnt bit set.
//   req bits >= NREQ do not exist; no requester is granted twice while another is pending
//     (round-robin fairness: max wait = NREQ-1 frames).
//   Reset mid-frame: immediate return to IDLE, outputs 0, ptr reset.
//     The in-flight response is discarded; the master must be reset with the same rst.
//
// TESTING
//   1 single: req=0010, req_data[1]=16'h1234, mode[1]=00 -> gnt=0010 and m_start at t+1;
//     m_slave_sel=1, m_din=1234; m_done with m_dout=CAFE -> rsp_valid, rsp_id=1, rsp_data=CAFE.
//   2 round-robin: req=1111 held, each m_done returned 8 cycles after m_start
//     -> gnt order 0,1,2,3,0; rsp_id matches; 4 idle-separated RESPs.
//   3 priority rotate: after grant to 2, req=0101 -> next gnt=0100? no: next gnt to 0?
//     ptr=2 so search 3,0 -> gnt=0001.
//   4 timeout: TIMEOUT=16, m_done never asserted -> rsp_valid 16 cycles after GRANT,
//     rsp_err=1, rsp_data=0, busy drops next cycle.
//   5 collision: m_done in last timeout cycle -> rsp_err=0, data captured; stray m_done in IDLE -> no rsp_valid.
//   6 reset mid-WAIT: rst=1 for 1 cycle -> all outputs 0 next cycle; then req=1000 -> gnt=1000
//     (ptr reset, 0 highest priority).

Source files
------------

// File: rtl/spi_txn_arbiter.sv
// rtl/spi_txn_arbiter.sv - round-robin arbiter sharing one SPI master among NREQ requesters
// Requester i always addresses slave i; a watchdog aborts frames whose done never arrives.
module spi_txn_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req,
  input  logic [16*NREQ-1:0]  req_data,
  input  logic [2*NREQ-1:0]   req_mode,
  output logic [NREQ-1:0]     gnt,
  output logic                rsp_valid,
  output logic [1:0]          rsp_id,
  output logic [15:0]         rsp_data,
  output logic                rsp_err,
  output logic                busy,
  output logic                m_start,
  output logic [15:0]         m_din,
  output logic [1:0]          m_mode,
  output logic [1:0]          m_slave_sel,
  input  logic                m_done,
  input  logic [15:0]         m_dout
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_WAIT, S_RESP} state_t;

  state_t          state;
  state_t          state_nxt;
  logic [1:0]      ptr;
  logic [1:0]      win;
  logic [1:0]      idx;
  logic            win_found;
  logic [CW-1:0]   wd_cnt;
  logic            wd_expired;

  // Search starts just past the last winner, so the previous grantee is considered last.
  always_comb begin
    win       = ptr;
    win_found = 1'b0;
    idx       = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = 2'((int'(ptr) + k) % NREQ);
      if (!win_found && req[idx]) begin
        win       = idx;
        win_found = 1'b1;
      end
    end
  end

  // wd_cnt holds the number of WAIT cycles already spent before the current one.
  assign wd_expired = (wd_cnt == CW'(TIMEOUT - 2));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (win_found) state_nxt = S_GRANT;
      S_GRANT: state_nxt = S_WAIT;
      S_WAIT:  if (m_done || wd_expired) state_nxt = S_RESP;
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    gnt       = '0;
    m_start   = 1'b0;
    rsp_valid = 1'b0;
    busy      = (state != S_IDLE);
    case (state)
      S_GRANT: begin
        gnt     = NREQ'(1) << m_slave_sel;
        m_start = 1'b1;
      end
      S_RESP:  rsp_valid = 1'b1;
      default: ;
    endcase
  end

  // The master word is captured on entry to GRANT so it is already valid alongside m_start.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr         <= 2'(NREQ - 1);
      wd_cnt      <= '0;
      m_din       <= '0;
      m_mode      <= '0;
      m_slave_sel <= '0;
      rsp_id      <= '0;
      rsp_data    <= '0;
      rsp_err     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (win_found) begin
            ptr         <= win;
            m_slave_sel <= win;
            m_din       <= req_data[16*int'(win) +: 16];
            m_mode      <= req_mode[2*int'(win) +: 2];
          end
        end
        S_GRANT: wd_cnt <= '0;
        S_WAIT: begin
          if (m_done) begin
            rsp_id   <= m_slave_sel;
            rsp_data <= m_dout;
            rsp_err  <= 1'b0;
          end else if (wd_expired) begin
            rsp_id   <= m_slave_sel;
            rsp_data <= '0;
            rsp_err  <= 1'b1;
          end else begin
            wd_cnt <= wd_cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// tb/tb_spi_txn_arbiter.sv - bench for spi_txn_arbiter with a transaction-level round-robin model
module tb_spi_txn_arbiter;
  localparam int NREQ = 4;
  localparam int TO   = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req;
  logic [16*NREQ-1:0] req_data;
  logic [2*NREQ-1:0] req_mode;
  logic [NREQ-1:0]   gnt;
  logic              rsp_valid;
  logic [1:0]        rsp_id;
  logic [15:0]       rsp_data;
  logic              rsp_err;
  logic              busy;
  logic              m_start;
  logic [15:0]       m_din;
  logic [1:0]        m_mode;
  logic [1:0]        m_slave_sel;
  logic              m_done;
  logic [15:0]       m_dout;

  logic [15:0] rd [NREQ];
  logic [1:0]  rm [NREQ];

  assign req_data = {rd[3], rd[2], rd[1], rd[0]};
  assign req_mode = {rm[3], rm[2], rm[1], rm[0]};

  always #5 clk = ~clk;

  spi_txn_arbiter #(.NREQ(NREQ), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .req_mode(req_mode),
    .gnt(gnt), .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .busy(busy), .m_start(m_start), .m_din(m_din),
    .m_mode(m_mode), .m_slave_sel(m_slave_sel), .m_done(m_done), .m_dout(m_dout)
  );

  int errs = 0;
  int checks = 0;

  typedef struct {
    logic [3:0]  req;
    int          lat;
    logic [15:0] dout;
    logic [3:0]  exp_gnt;
    int          exp_id;
    logic        exp_err;
    logic [15:0] exp_data;
  } vec_t;

  vec_t tbl [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gnt"},       32'(gnt), 0);
    chk({tag, "_m_start"},   32'(m_start), 0);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
    chk({tag, "_rsp_id"},    32'(rsp_id), 0);
    chk({tag, "_rsp_data"},  32'(rsp_data), 0);
    chk({tag, "_rsp_err"},   32'(rsp_err), 0);
    chk({tag, "_busy"},      32'(busy), 0);
    chk({tag, "_m_din"},     32'(m_din), 0);
    chk({tag, "_m_mode"},    32'(m_mode), 0);
    chk({tag, "_m_sel"},     32'(m_slave_sel), 0);
  endtask

  // Entered in an IDLE cycle; lat = cycles from m_start to m_done, lat >= TO means no done.
  task automatic check_frame(input logic [3:0] r, input int lat, input logic [15:0] dout,
                             input logic [3:0] eg, input int eid, input logic eerr,
                             input logic [15:0] edata, input logic stray);
    int resp_at;
    resp_at = (lat < TO) ? lat + 1 : TO;
    chk("idle_busy", 32'(busy), 0);
    req    = r;
    m_done = stray;
    m_dout = 16'hDEAD;
    @(posedge clk); #1;
    chk("gnt", 32'(gnt), 32'(eg));
    chk("m_start", 32'(m_start), 1);
    chk("grant_rsp_valid", 32'(rsp_valid), 0);
    chk("m_din", 32'(m_din), 32'(rd[eid]));
    chk("m_mode", 32'(m_mode), 32'(rm[eid]));
    chk("m_slave_sel", 32'(m_slave_sel), 32'(eid));
    req    = r & ~eg;
    m_done = stray;
    for (int k = 1; k <= resp_at; k++) begin
      @(posedge clk); #1;
      if (k < resp_at) begin
        chk("wait_rsp_valid", 32'(rsp_valid), 0);
        chk("wait_busy", 32'(busy), 1);
        chk("wait_gnt_start", 32'({gnt, m_start}), 0);
        chk("wait_m_din", 32'(m_din), 32'(rd[eid]));
      end else begin
        chk("rsp_valid", 32'(rsp_valid), 1);
        chk("rsp_id", 32'(rsp_id), 32'(eid));
        chk("rsp_data", 32'(rsp_data), 32'(edata));
        chk("rsp_err", 32'(rsp_err), 32'(eerr));
        chk("resp_gnt_start", 32'({gnt, m_start}), 0);
      end
      m_done = (k == lat);
      m_dout = dout;
    end
    @(posedge clk); #1;
    m_done = 1'b0;
    chk("after_busy", 32'(busy), 0);
    chk("after_rsp_valid", 32'(rsp_valid), 0);
    chk("hold_rsp_data", 32'(rsp_data), 32'(edata));
  endtask

  logic [3:0]  pend;
  int          exp_ptr;
  int          w;
  int          lat;
  logic [15:0] dout;
  logic        eerr;

  initial begin
    rd[0] = 16'h0F0F; rm[0] = 2'b01;
    rd[1] = 16'h1234; rm[1] = 2'b00;
    rd[2] = 16'h5A5A; rm[2] = 2'b10;
    rd[3] = 16'h8001; rm[3] = 2'b11;
    tbl[0]  = '{4'b0010, 8,      16'hCAFE, 4'b0010, 1, 1'b0, 16'hCAFE};
    tbl[1]  = '{4'b0101, 3,      16'h0001, 4'b0100, 2, 1'b0, 16'h0001};
    tbl[2]  = '{4'b0101, 5,      16'h0002, 4'b0001, 0, 1'b0, 16'h0002};
    tbl[3]  = '{4'b1111, 2,      16'h0003, 4'b0010, 1, 1'b0, 16'h0003};
    tbl[4]  = '{4'b1111, 1,      16'h0004, 4'b0100, 2, 1'b0, 16'h0004};
    tbl[5]  = '{4'b1111, 6,      16'hFFFF, 4'b1000, 3, 1'b0, 16'hFFFF};
    tbl[6]  = '{4'b1111, 9,      16'h8000, 4'b0001, 0, 1'b0, 16'h8000};
    tbl[7]  = '{4'b1010, TO + 5, 16'hBEEF, 4'b0010, 1, 1'b1, 16'h0000};
    tbl[8]  = '{4'b1000, TO - 1, 16'h5555, 4'b1000, 3, 1'b0, 16'h5555};
    tbl[9]  = '{4'b0110, 1,      16'hAAAA, 4'b0010, 1, 1'b0, 16'hAAAA};
    tbl[10] = '{4'b1001, 3,      16'h0F00, 4'b1000, 3, 1'b0, 16'h0F00};

    rst = 1'b1; req = '0; m_done = 1'b0; m_dout = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst = 1'b0;

    // A done pulse with nothing in flight must never produce a response.
    m_done = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      chk("stray_rsp_valid", 32'(rsp_valid), 0);
      chk("stray_busy", 32'(busy), 0);
    end
    m_done = 1'b0;

    for (int i = 0; i < 11; i++)
      check_frame(tbl[i].req, tbl[i].lat, tbl[i].dout, tbl[i].exp_gnt,
                  tbl[i].exp_id, tbl[i].exp_err, tbl[i].exp_data, 1'(i % 2));

    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 5; i++)
      check_frame(4'hF, 8, 16'(16'h0100 + i), 4'(1 << (i % 4)), i % 4, 1'b0,
                  16'(16'h0100 + i), 1'b0);

    req = 4'b0010;
    @(posedge clk); #1;
    chk("rst_seq_gnt", 32'(gnt), 32'h2);
    req = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk_all_zero("midrst");
    check_frame(4'b1001, 4, 16'h7777, 4'b0001, 0, 1'b0, 16'h7777, 1'b1);
    check_frame(4'b1000, 2, 16'h3333, 4'b1000, 3, 1'b0, 16'h3333, 1'b0);

    pend = '0;
    exp_ptr = 3;
    for (int f = 0; f < 150; f++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i] && ($urandom_range(0, 1) == 1)) begin
          pend[i] = 1'b1;
          rd[i] = 16'($urandom);
          rm[i] = 2'($urandom);
        end
      end
      if (pend == '0) begin
        w = int'($urandom_range(0, NREQ - 1));
        pend[w] = 1'b1;
        rd[w] = 16'($urandom);
        rm[w] = 2'($urandom);
      end
      w = -1;
      for (int k = 1; k <= NREQ; k++)
        if (w < 0 && pend[(exp_ptr + k) % NREQ]) w = (exp_ptr + k) % NREQ;
      lat  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(TO - 1, TO + 2))
                                         : int'($urandom_range(1, 12));
      dout = 16'($urandom);
      eerr = (lat >= TO);
      check_frame(pend, lat, dout, 4'(1 << w), w, eerr, eerr ? 16'h0000 : dout,
                  1'($urandom_range(0, 1)));
      pend[w] = 1'b0;
      exp_ptr = w;
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
